// File: rtl/register_file_io.sv
// Architectural register file with a write-back output-port FIFO drained by valid/ready.
// Define WB_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_io #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readAddress1,
  output logic [DATA_WIDTH-1:0] readData1,
  input  logic [ADDR_WIDTH-1:0] readAddress2,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  outputEnable,
  input  logic [DATA_WIDTH-1:0] outputData,
  output logic [DATA_WIDTH-1:0] portData,
  output logic                  portValid,
  input  logic                  portReady,
  output logic                  portFull,
  output logic                  portOverflow
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [DATA_WIDTH-1:0] fifo_q [OUT_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] port_data_q, port_data_d;
  logic                  push, pop;

  always_comb begin
    regs_d = regs_q;
    if (regWrite) regs_d[writeAddress] = writeData;
  end

  always_comb begin
    readData1 = regs_q[readAddress1];
    readData2 = regs_q[readAddress2];
`ifdef WB_BYPASS_EN
    if (regWrite && (readAddress1 == writeAddress)) readData1 = writeData;
    if (regWrite && (readAddress2 == writeAddress)) readData2 = writeData;
`endif
  end

  always_comb begin
    pop         = (count_q != '0) && portReady;
    // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
    push        = outputEnable && ((count_q != FULL_CNT) || pop);
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (outputEnable & ~push);
    port_data_d = port_data_q;
    if (push) begin
      fifo_d[wr_ptr_q] = outputData;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Head is registered; once empty it keeps the last popped value.
    if (count_d != '0) port_data_d = fifo_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '{default: '0};
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      port_data_q <= '0;
    end else begin
      regs_q      <= regs_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      port_data_q <= port_data_d;
    end
  end

  assign portData     = port_data_q;
  assign portValid    = (count_q != '0);
  assign portFull     = (count_q == FULL_CNT);
  assign portOverflow = overflow_q;

endmodule

// File: tb/tb_register_file_io.sv
// Directed self-checking bench for register_file_io (default parameters).
module tb_register_file_io;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        regWrite = 1'b0;
  logic [2:0]  writeAddress = '0;
  logic [15:0] writeData = '0;
  logic [2:0]  readAddress1 = '0;
  logic [15:0] readData1;
  logic [2:0]  readAddress2 = '0;
  logic [15:0] readData2;
  logic        outputEnable = 1'b0;
  logic [15:0] outputData = '0;
  logic [15:0] portData;
  logic        portValid;
  logic        portReady = 1'b0;
  logic        portFull;
  logic        portOverflow;

  int n_tests = 0;
  int n_fail  = 0;

  register_file_io #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .regWrite(regWrite), .writeAddress(writeAddress), .writeData(writeData),
    .readAddress1(readAddress1), .readData1(readData1),
    .readAddress2(readAddress2), .readData2(readData2),
    .outputEnable(outputEnable), .outputData(outputData),
    .portData(portData), .portValid(portValid), .portReady(portReady),
    .portFull(portFull), .portOverflow(portOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic rdy);
    outputEnable = 1'b1;
    outputData   = d;
    portReady    = rdy;
    step();
    outputEnable = 1'b0;
    portReady    = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check(tag, portData, exp);
    check({tag, "_valid"}, 16'(portValid), 16'd1);
    portReady = 1'b1;
    step();
    portReady = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd1", readData1, 16'h0000);
    check("rst_valid", 16'(portValid), 16'd0);
    check("rst_full", 16'(portFull), 16'd0);
    check("rst_ovf", 16'(portOverflow), 16'd0);
    check("rst_pdata", portData, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    step();

    // write then read on both ports
    regWrite = 1'b1; writeAddress = 3'd5; writeData = 16'h1234;
    step();
    regWrite = 1'b0; readAddress1 = 3'd5; readAddress2 = 3'd5;
    #1;
    check("wr_r5_p1", readData1, 16'h1234);
    check("wr_r5_p2", readData2, 16'h1234);

    // same-cycle write and read
    regWrite = 1'b1; writeAddress = 3'd3; writeData = 16'h0007;
    step();
    writeData = 16'hBEEF; readAddress1 = 3'd3; readAddress2 = 3'd5;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_same", readData1, 16'hBEEF);
`else
    check("byp_same", readData1, 16'h0007);
`endif
    check("byp_other", readData2, 16'h1234);
    step();
    regWrite = 1'b0;
    #1;
    check("byp_next", readData1, 16'hBEEF);

    // fill, overflow, drain
    push(16'h00A1, 1'b0);
    check("push1_valid", 16'(portValid), 16'd1);
    check("push1_head", portData, 16'h00A1);
    check("push1_full", 16'(portFull), 16'd0);
    push(16'h00A2, 1'b0);
    push(16'h00A3, 1'b0);
    push(16'h00A4, 1'b0);
    check("fill_full", 16'(portFull), 16'd1);
    check("fill_ovf", 16'(portOverflow), 16'd0);
    push(16'h00A5, 1'b0);
    check("ovf_set", 16'(portOverflow), 16'd1);
    check("ovf_full", 16'(portFull), 16'd1);
    check("ovf_head", portData, 16'h00A1);
    step();
    check("hold_head", portData, 16'h00A1);
    pop_check("drain1", 16'h00A1);
    check("drain_notfull", 16'(portFull), 16'd0);
    pop_check("drain2", 16'h00A2);
    pop_check("drain3", 16'h00A3);
    pop_check("drain4", 16'h00A4);
    check("drain_empty", 16'(portValid), 16'd0);
    check("drain_last", portData, 16'h00A4);
    check("ovf_sticky", 16'(portOverflow), 16'd1);

    // async reset mid-run with two entries queued
    push(16'h00D1, 1'b0);
    push(16'h00D2, 1'b0);
    check("pre_rst_valid", 16'(portValid), 16'd1);
    readAddress1 = 3'd5; readAddress2 = 3'd3;
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_rd1", readData1, 16'h0000);
    check("mrst_rd2", readData2, 16'h0000);
    check("mrst_valid", 16'(portValid), 16'd0);
    check("mrst_ovf", 16'(portOverflow), 16'd0);
    check("mrst_pdata", portData, 16'h0000);
    step();
    rst_n = 1'b1;
    step();

    // full FIFO with simultaneous push and pop
    push(16'h00A1, 1'b0);
    push(16'h00A2, 1'b0);
    push(16'h00A3, 1'b0);
    push(16'h00A4, 1'b0);
    push(16'h00B0, 1'b1);
    check("pp_full", 16'(portFull), 16'd1);
    check("pp_head", portData, 16'h00A2);
    check("pp_ovf", 16'(portOverflow), 16'd0);
    pop_check("pp_d1", 16'h00A2);
    pop_check("pp_d2", 16'h00A3);
    pop_check("pp_d3", 16'h00A4);
    pop_check("pp_d4", 16'h00B0);
    check("pp_empty", 16'(portValid), 16'd0);

    // pointer wrap: continuous push/pop, occupancy stays at one
    portReady = 1'b1;
    outputEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      outputData = 16'h00C0 + 16'(i);
      step();
      check("wrap_head", portData, 16'h00C0 + 16'(i));
      check("wrap_valid", 16'(portValid), 16'd1);
      check("wrap_full", 16'(portFull), 16'd0);
    end
    outputEnable = 1'b0;
    step();
    portReady = 1'b0;
    check("wrap_empty", 16'(portValid), 16'd0);
    check("wrap_last", portData, 16'h00C9);
    check("wrap_ovf", 16'(portOverflow), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
